fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the async FIFO (`main`) among `NUM_REQ` producers in the write clock domain. Each producer uses a valid/ready handshake. The arbiter drives the FIFO's `wr_en`/`data_in` and backs off on `fifo_full`. It sits between the producer blocks and the FIFO write side, entirely in the `wr_clk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `DATA_WIDTH`, default 8: FIFO word width; matches the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant when burst mode is compiled in (≥1).

Ports:
- `wr_clk` in 1: write-domain clock; all logic on rising edge.
- `wr_rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester word available.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: one-hot or zero; word i accepted when `req_valid[i] & req_ready[i]`.
- `fifo_full` in 1: FIFO full flag.
- `wr_en` out 1: FIFO write enable.
- `data_in` out `DATA_WIDTH`: FIFO write data.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current owner.
- `busy` out 1: state is GRANT.
- `stall_cnt` out 16: saturating count of cycles spent in GRANT with `fifo_full` high.

## Operation
- **States:**
  - IDLE: arbitrate.
  - GRANT: the owner transfers.
- **IDLE:**
  - If any `req_valid`, pick the first asserted index searching upward from `last_id+1`, wrapping at `NUM_REQ-1`→0.
  - Register it as `grant_id` and `last_id`, clear `beat_cnt`, and go to GRANT.
  - If no request, stay in IDLE.
- **GRANT:**
  - `req_ready[grant_id] = ~fifo_full`.
  - `wr_en = req_valid[grant_id] & ~fifo_full`.
  - `data_in` = owner's slice (combinational mux).
  - A beat transfers when `wr_en` is high; `beat_cnt` increments.
- **GRANT exit** to IDLE on the edge where any of these holds:
  - A beat transfers and the burst limit is reached.
  - `req_valid[grant_id]` is low. Dropping valid before transfer releases the grant without a write.
- **Full backpressure:** while `fifo_full` is high in GRANT, hold the grant with no timeout, keep `wr_en=0`, and increment `stall_cnt`, saturating at 16'hFFFF.
- **Data stability:** a requester must hold `req_valid` and `req_data` stable until accepted.
- **Fairness:** the winner becomes lowest priority at the next arbitration.
- **Outputs outside GRANT:** `wr_en`, `req_ready`, and `busy` are 0; `data_in` is don't-care but driven from `grant_id` (no X).

## Timing
- **Reset values:**
  - state IDLE; `grant_id=0`; `last_id=NUM_REQ-1`, so requester 0 wins first.
  - `beat_cnt=0`, `stall_cnt=0`, `busy=0`, `wr_en=0`, `req_ready=0`.
- **Reset gating:** while `wr_rst` is high, `wr_en` and `req_ready` are forced 0 combinationally. A reset mid-burst drops the grant with no partial write.
- **Grant latency:** `req_valid` seen in IDLE at edge n → `busy=1` and first `wr_en` in cycle n+1 if not full.
- **Re-arbitration bubble:** exactly one IDLE cycle between grants, including back-to-back grants to the same requester.
- **Combinational path:** `fifo_full` → `wr_en`/`req_ready` is combinational, so no write is issued in a cycle where `fifo_full=1`.
- **Simultaneous events:** a transfer on the last beat plus a new `fifo_full` assertion still exits to IDLE; the full flag affects the next grant only.
- **Counter width:** `beat_cnt` is `$clog2(MAX_BURST+1)` bits.

## Configuration
- **`FIFO_ARB_BURST_EN` defined:** a grant lasts up to `MAX_BURST` transferred beats. It ends early if the owner drops valid. Peak throughput is `MAX_BURST` words per `MAX_BURST+1` cycles.
- **Not defined:** every grant ends after one transferred beat (limit fixed at 1). Throughput is 1 word per 2 cycles; `MAX_BURST` is ignored.

## Structure
- **Package `fifo_arb_pkg`:**
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e`.
  - `STALL_CNT_W = 16`.
  - Helper function for the wrap-around next index.
- **Sub-module `rr_pick`:** combinational, parameter `NUM_REQ`. Inputs are the request vector and `last_id`; outputs are `found` and `pick_id`. Instantiated once in IDLE.

## Test plan
- **Single requester:** reset, then `req_valid=4'b0100` with data 8'hA5 → `grant_id=2` and `busy=1` next cycle, `wr_en=1` with `data_in=8'hA5` in that cycle, IDLE the cycle after.
- **All four requesting continuously, burst off:** grant order 0,1,2,3,0…; one write every 2 cycles; 8 writes in 16 cycles.
- **Burst on, `MAX_BURST=4`, requester 1 valid for 6 words:** 4 consecutive writes, 1 IDLE cycle, then 2 more writes; `grant_id=1` throughout.
- **`fifo_full` high for 5 cycles mid-grant:** `wr_en=0` and `req_ready=0` for those 5 cycles; `stall_cnt` increases by 5; grant retained; data word written once full drops, with no loss or duplication.
- **Reset mid-burst:** assert `wr_rst` during beat 2 → `wr_en=0` that cycle; next cycle IDLE with `stall_cnt=0`; requester 0 wins next.
- **Owner drops valid before transfer while full:** returns to IDLE with no write; the next requester in round-robin order is granted.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//
// Contents:
//   arb_state_e  - arbiter FSM states (idle/arbitrate, grant/transfer)
//   STALL_CNT_W  - width of the saturating full-stall counter
//   next_index() - round-robin successor of an index, wrapping at num_req-1
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    localparam int STALL_CNT_W = 16;

    function automatic int next_index(input int idx, input int num_req);
        return (idx >= num_req - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the producer valid/ready handshake and the
// FIFO write-side signals shared by the arbiter and its environment.
//
// Signals:
//   req_valid [NUM_REQ]            per-producer word available
//   req_data  [NUM_REQ*DATA_WIDTH] producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready [NUM_REQ]            one-hot or zero accept
//   fifo_full                      FIFO full flag
//   wr_en                          FIFO write enable
//   data_in   [DATA_WIDTH]         FIFO write data
// Modports:
//   master - producers + FIFO side (drives requests and the full flag)
//   slave  - the arbiter (drives ready, write enable and write data)
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, wr_en, data_in
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, wr_en, data_in
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//
// Ports:
//   req     in  [NUM_REQ]          request vector
//   last_id in  [clog2(NUM_REQ)]   most recent winner (lowest priority)
//   found   out                    at least one request is asserted
//   pick_id out [clog2(NUM_REQ)]   first asserted index above last_id, wrapping
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] pick_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Walk the candidates starting just above last_id; the inner loop keeps
    // every bit select constant so the search unrolls into plain muxing.
    always_comb begin
        int idx;
        found   = 1'b0;
        pick_id = '0;
        idx     = next_index(int'(last_id), NUM_REQ);
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && req[i] && !found) begin
                    found   = 1'b1;
                    pick_id = ID_W'(i);
                end
            end
            idx = next_index(idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async FIFO write port
// among NUM_REQ producers, entirely in the wr_clk domain.
//
// Ports:
//   wr_clk    in   write-domain clock, rising edge
//   wr_rst    in   synchronous active-high reset
//   bus       slave modport of fifo_wr_arbiter_if (handshakes + FIFO write side)
//   grant_id  out  index of the current owner
//   busy      out  high while in the GRANT state
//   stall_cnt out  saturating count of GRANT cycles with fifo_full high
//
// Build option: define FIFO_ARB_BURST_EN to let a grant carry up to MAX_BURST
// beats; otherwise every grant ends after a single transferred beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    fifo_wr_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [STALL_CNT_W-1:0]     stall_cnt
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
`ifdef FIFO_ARB_BURST_EN
    localparam int BURST_LIMIT = MAX_BURST;
`else
    localparam int BURST_LIMIT = 1;
`endif

    arb_state_e            state;
    arb_state_e            next_state;
    logic [ID_W-1:0]       last_id;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  found;
    logic [ID_W-1:0]       pick_id;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] data_sel;
    logic                  last_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .last_id (last_id),
        .found   (found),
        .pick_id (pick_id)
    );

    // Owner's valid bit and data slice. Outside GRANT the mux still follows
    // grant_id so data_in never floats to X.
    always_comb begin
        owner_valid = 1'b0;
        data_sel    = bus.req_data[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_valid = bus.req_valid[i];
                data_sel    = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // fifo_full and wr_rst gate the handshake combinationally, so no write
    // can leave in a full cycle or in the reset cycle of an interrupted burst.
    always_comb begin
        bus.req_ready = '0;
        bus.wr_en     = 1'b0;
        bus.data_in   = data_sel;
        if (state == ARB_GRANT && !wr_rst && !bus.fifo_full) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_ready[i] = (grant_id == ID_W'(i));
            end
            bus.wr_en = owner_valid;
        end
    end

    assign last_beat = (beat_cnt == BEAT_W'(BURST_LIMIT - 1));
    assign busy      = (state == ARB_GRANT);

    // A grant ends when its final beat moves or the owner withdraws; a full
    // FIFO alone never ends it.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:  if (found) next_state = ARB_GRANT;
            ARB_GRANT: if (!owner_valid || (bus.wr_en && last_beat)) next_state = ARB_IDLE;
            default:   next_state = ARB_IDLE;
        endcase
    end

    // last_id starts at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state     <= ARB_IDLE;
            grant_id  <= '0;
            last_id   <= ID_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && found) begin
                grant_id <= pick_id;
                last_id  <= pick_id;
                beat_cnt <= '0;
            end
            if (state == ARB_GRANT && bus.wr_en) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            if (state == ARB_GRANT && bus.fifo_full && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well clear of the rising edge. Expected values are hand-derived per scenario;
// the burst-dependent ones are selected with FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
    localparam int LIMIT = 4;
    localparam logic [0:11] EXP_BURST_WR = 12'b0111_1011_0000;
    localparam int RST_CYC = 4;
`else
    localparam int LIMIT = 1;
    localparam logic [0:11] EXP_BURST_WR = 12'b0101_0101_0101;
    localparam int RST_CYC = 5;
`endif

    localparam logic [31:0] BASE_DATA = {8'hD3, 8'hA5, 8'hB1, 8'hC0};

    logic        wr_clk = 1'b0;
    logic        wr_rst;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] wr_data_q[$];
    logic [1:0] wr_id_q[$];
    logic [7:0] req_bytes [4];

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    // One clock cycle of stimulus; every write the DUT issues is logged.
    task automatic drive_cycle(input logic [3:0] valid, input logic [31:0] data,
                               input logic full, input logic rst_in);
        @(negedge wr_clk);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.fifo_full = full;
        wr_rst        = rst_in;
        #1;
        if (bus.wr_en === 1'b1) begin
            wr_data_q.push_back(bus.data_in);
            wr_id_q.push_back(grant_id);
        end
    endtask

    task automatic apply_reset();
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b1);
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b1);
        wr_data_q.delete();
        wr_id_q.delete();
    endtask

    task automatic test_reset();
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b1);
        drive_cycle(4'b1111, BASE_DATA, 1'b0, 1'b1);
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        wr_data_q.delete();
        wr_id_q.delete();
    endtask

    task automatic test_single();
        apply_reset();
        drive_cycle(4'b0100, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
        drive_cycle(4'b0100, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("[TB] FAIL single_grant_id: got %0d want 2", grant_id); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_err++; $display("[TB] FAIL single_wr_en: got %b want 1", bus.wr_en); end
        n_cmp++; if (bus.data_in !== 8'hA5) begin n_err++; $display("[TB] FAIL single_data_in: got %h want a5", bus.data_in); end
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL single_req_ready: got %b want 0100", bus.req_ready); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (busy !== (LIMIT > 1)) begin n_err++; $display("[TB] FAIL single_after_busy: got %b want %b", busy, (LIMIT > 1)); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL single_after_wr_en: got %b want 0", bus.wr_en); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_final_busy: got %b want 0", busy); end
        n_cmp++; if (wr_data_q.size() !== 1) begin n_err++; $display("[TB] FAIL single_write_count: got %0d want 1", wr_data_q.size()); end
    endtask

    task automatic test_round_robin();
        int exp_writes;
        int exp_id;
        apply_reset();
        for (int c = 0; c < 16; c++) drive_cycle(4'b1111, BASE_DATA, 1'b0, 1'b0);
        // first cycle is the arbitration bubble; then groups of LIMIT writes + 1 idle
        exp_writes = (15 / (LIMIT + 1)) * LIMIT
                   + (((15 % (LIMIT + 1)) < LIMIT) ? (15 % (LIMIT + 1)) : LIMIT);
        n_cmp++; if (wr_id_q.size() !== exp_writes) begin n_err++; $display("[TB] FAIL rr_write_count: got %0d want %0d", wr_id_q.size(), exp_writes); end
        for (int k = 0; k < wr_id_q.size(); k++) begin
            exp_id = (k / LIMIT) % 4;
            n_cmp++; if (wr_id_q[k] !== 2'(exp_id)) begin n_err++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", k, wr_id_q[k], exp_id); end
            n_cmp++; if (wr_data_q[k] !== req_bytes[exp_id]) begin n_err++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", k, wr_data_q[k], req_bytes[exp_id]); end
        end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
    endtask

    task automatic test_burst();
        int sent;
        logic [31:0] d;
        sent = 0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            d = BASE_DATA;
            d[15:8] = 8'h10 + 8'(sent);
            drive_cycle((sent < 6) ? 4'b0010 : 4'b0000, d, 1'b0, 1'b0);
            n_cmp++; if (bus.wr_en !== EXP_BURST_WR[c]) begin n_err++; $display("[TB] FAIL burst_wr_en[c%0d]: got %b want %b", c, bus.wr_en, EXP_BURST_WR[c]); end
            if (bus.wr_en === 1'b1 && bus.req_ready[1] === 1'b1) sent++;
        end
        n_cmp++; if (wr_data_q.size() !== 6) begin n_err++; $display("[TB] FAIL burst_write_count: got %0d want 6", wr_data_q.size()); end
        for (int k = 0; k < wr_data_q.size(); k++) begin
            n_cmp++; if (wr_data_q[k] !== 8'h10 + 8'(k)) begin n_err++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", k, wr_data_q[k], 8'h10 + 8'(k)); end
            n_cmp++; if (wr_id_q[k] !== 2'd1) begin n_err++; $display("[TB] FAIL burst_grant[%0d]: got %0d want 1", k, wr_id_q[k]); end
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        drive_cycle(4'b1000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL stall_idle_busy: got %b want 0", busy); end
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(4'b1000, BASE_DATA, 1'b1, 1'b0);
            n_cmp++; if (bus.wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL stall_wr_en[c%0d]: got %b want 0", c, bus.wr_en); end
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL stall_req_ready[c%0d]: got %b want 0000", c, bus.req_ready); end
            n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd3) begin n_err++; $display("[TB] FAIL stall_hold[c%0d]: got busy=%b id=%0d want busy=1 id=3", c, busy, grant_id); end
            n_cmp++; if (stall_cnt !== 16'(c - 1)) begin n_err++; $display("[TB] FAIL stall_cnt[c%0d]: got %0d want %0d", c, stall_cnt, c - 1); end
        end
        drive_cycle(4'b1000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("[TB] FAIL stall_total: got %0d want 5", stall_cnt); end
        n_cmp++; if (bus.wr_en !== 1'b1) begin n_err++; $display("[TB] FAIL stall_release_wr_en: got %b want 1", bus.wr_en); end
        n_cmp++; if (bus.data_in !== 8'hD3) begin n_err++; $display("[TB] FAIL stall_release_data: got %h want d3", bus.data_in); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (wr_data_q.size() !== 1) begin n_err++; $display("[TB] FAIL stall_write_count: got %0d want 1", wr_data_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        for (int c = 0; c <= RST_CYC + 2; c++) begin
            drive_cycle(4'b0011, BASE_DATA, (c == 1 || c == 2), (c == RST_CYC));
            if (c == 3) begin
                n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("[TB] FAIL midrst_pre_stall: got %0d want 2", stall_cnt); end
            end
            if (c == RST_CYC) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy); end
                n_cmp++; if (bus.wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_wr_en: got %b want 0", bus.wr_en); end
                n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL midrst_req_ready: got %b want 0000", bus.req_ready); end
            end
            if (c == RST_CYC + 1) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_idle: got %b want 0", busy); end
                n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL midrst_stall_clr: got %0d want 0", stall_cnt); end
            end
            if (c == RST_CYC + 2) begin
                n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_regrant: got id=%0d busy=%b want id=0 busy=1", grant_id, busy); end
                n_cmp++; if (bus.wr_en !== 1'b1 || bus.data_in !== 8'hC0) begin n_err++; $display("[TB] FAIL midrst_write: got wr_en=%b data=%h want 1/c0", bus.wr_en, bus.data_in); end
            end
        end
        n_cmp++; if (wr_data_q.size() !== 2) begin n_err++; $display("[TB] FAIL midrst_write_count: got %0d want 2", wr_data_q.size()); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
    endtask

    task automatic test_drop_while_full();
        apply_reset();
        drive_cycle(4'b0101, BASE_DATA, 1'b1, 1'b0);
        drive_cycle(4'b0101, BASE_DATA, 1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL drop_grant0: got busy=%b id=%0d want 1/0", busy, grant_id); end
        drive_cycle(4'b0100, BASE_DATA, 1'b1, 1'b0);
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL drop_no_write: got %b want 0", bus.wr_en); end
        drive_cycle(4'b0100, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL drop_idle: got %b want 0", busy); end
        drive_cycle(4'b0100, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_err++; $display("[TB] FAIL drop_next_grant: got id=%0d busy=%b want 2/1", grant_id, busy); end
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.data_in !== 8'hA5) begin n_err++; $display("[TB] FAIL drop_next_write: got wr_en=%b data=%h want 1/a5", bus.wr_en, bus.data_in); end
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        drive_cycle(4'b0000, BASE_DATA, 1'b0, 1'b0);
        n_cmp++; if (wr_data_q.size() !== 1) begin n_err++; $display("[TB] FAIL drop_write_count: got %0d want 1", wr_data_q.size()); end
    endtask

    initial begin
        req_bytes     = '{8'hC0, 8'hB1, 8'hA5, 8'hD3};
        wr_rst        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = BASE_DATA;
        bus.fifo_full = 1'b0;
        $display("[TB] start, burst limit %0d", LIMIT);
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_full_stall();
        test_reset_mid_burst();
        test_drop_while_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
